spi_cpu_top: RTL and testbench
==============================

# spi_cpu_top

Tiny 4-bit-opcode accumulator CPU for a TinyTapeout tile that executes its program directly from an external SPI serial RAM. Each program byte is fetched with a SPI READ (0x03) transaction and holds two instructions, high nibble first. Operands come from `ui_in`. Results appear on `uo_out` with a one-cycle valid strobe.

## Interface
- No parameters. SCK is fixed at clk/2.
- `clk` in 1: system clock, the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: tile enable; ignored.
- `ui_in` in 8: operands; `[3:0]` feeds A, `[7:4]` feeds B.
- `uo_out` out 8: `[6:0]`=OUT[6:0], `[7]`=valid strobe.
- `uio_in` in 8: `[2]`=MISO; other bits ignored.
- `uio_out` out 8: `[0]`=CS_n, `[1]`=MOSI, `[3]`=SCK, `[7]`=OUT[7]; other bits 0.
- `uio_oe` out 8: constant 8'b1000_1011.

## Operation
- Registers (8-bit): A, B, S (accumulator), OUT, PC.
- States:
  - RESET→FETCH.
  - FETCH runs a SPI read of byte PC and latches IR.
  - EXEC_HI executes IR[7:4].
  - EXEC_LO executes IR[3:0], then PC←PC+1 (wraps 255→0) and returns to FETCH.
- Opcodes:
  - 0 LDA: A←{0,ui_in[3:0]}
  - 1 LDB: B←{0,ui_in[7:4]}
  - 2 LDO: OUT←S, valid=1
  - 3 LDSA: S←A
  - 4 LDSB: S←B
  - 5 LSH: S←S<<1, zero fill
  - 6 RSH: S←S>>1, logical
  - 7 CLR: S←0
  - 8 SNZ A: skip next nibble if A≠0
  - 9 SNZ S: skip next nibble if S≠0
  - A ADD: S←A+B
  - B SUB: S←A−B
  - C AND, D OR, E XOR: S←A op B (see Configuration)
  - F NOP
- All arithmetic is modulo 256. There are no flags.
- A skip discards the next nibble in program order. From EXEC_LO, that is the high nibble of the next fetched byte. A skipped nibble takes its normal cycle as a NOP.
- SPI transaction, mode 0, MSB first:
  - CS_n low.
  - Shift out 0x03, then a 16-bit address {8'h00, PC}.
  - Shift in 8 data bits.
  - CS_n high for at least 2 clk.
- MOSI changes only while SCK is low. MISO is sampled on the clk edge that raises SCK.
- No jumps. The program runs linearly and forever.

## Timing
- Reset (async assert) forces:
  - CS_n=1, SCK=0, MOSI=0
  - A=B=S=OUT=PC=0, valid=0
  - `uo_out`=0x00, `uio_out`=0x01
- Release: the first CS_n fall occurs on the 1st–2nd clk after `rst_n` rises.
- SCK toggles every clk while CS_n is low: exactly 32 rising edges per transaction (24 out, 8 in).
- Fetch takes 64 clk with CS_n low, plus 2 clk deselect. EXEC_HI and EXEC_LO take 1 clk each. One byte costs 68 clk.
- Register updates take effect at the end of the execute cycle.
- valid is high for exactly the clk after LDO executes, coincident with the new OUT. Back-to-back LDOs produce separate pulses.
- `ui_in` is sampled on the clk edge ending LDA/LDB.
- Reset mid-fetch: CS_n deasserts immediately and fetch restarts at address 0.

## Configuration
- `SPI_CPU_LOGIC_OPS_EN`:
  - Defined: opcodes C/D/E perform AND/OR/XOR into S.
  - Undefined: C/D/E behave as NOP. No logic-op hardware is generated.

## Structure
- Package `spi_cpu_pkg` holds:
  - opcode localparams (OP_LDA…OP_NOP)
  - FSM state enum
  - SPI_CMD_READ=8'h03, ADDR_BITS=16
- One sub-module `spi_read_master`:
  - Inputs: start, 8-bit addr, miso.
  - Outputs: cs_n, sck, mosi, data[7:0], done.
- The top holds the CPU FSM, registers and ALU.

## Test plan
- Reset, then first fetch:
  - MOSI bytes 0x03, 0x00, 0x00; CS_n low for 32 SCK rises.
  - Second transaction address byte is 0x01.
- mem[0]=0x10, mem[1]=0xA2, `ui_in`=0x35:
  - A=5, B=3, uo_out[6:0]=0x08.
  - valid high exactly 1 clk.
- Same with mem[1]=0xB2: OUT=0x02.
- Same with mem[1]=0x35, mem[2]=0x2F: S=5, then LSH gives S=0x0A, OUT=0x0A.
- mem[0]=0x08 (LDA, SNZ A), mem[1]=0x32, `ui_in`=0x05: LDSA is skipped, so OUT=0x00 with valid. With `ui_in`=0x00: OUT=0x00, S=0.
- Assert `rst_n` mid-transaction:
  - CS_n high immediately, all registers 0.
  - After release, a fetch from address 0x00.

Source files
------------

// File: rtl/spi_cpu_pkg.sv
// Shared opcodes, FSM state types and SPI framing constants for the SPI-fed accumulator CPU.
// Pure declarations; no latency or backpressure of its own.
package spi_cpu_pkg;

   localparam logic [3:0] OP_LDA  = 4'h0;
   localparam logic [3:0] OP_LDB  = 4'h1;
   localparam logic [3:0] OP_LDO  = 4'h2;
   localparam logic [3:0] OP_LDSA = 4'h3;
   localparam logic [3:0] OP_LDSB = 4'h4;
   localparam logic [3:0] OP_LSH  = 4'h5;
   localparam logic [3:0] OP_RSH  = 4'h6;
   localparam logic [3:0] OP_CLR  = 4'h7;
   localparam logic [3:0] OP_SNZA = 4'h8;
   localparam logic [3:0] OP_SNZS = 4'h9;
   localparam logic [3:0] OP_ADD  = 4'hA;
   localparam logic [3:0] OP_SUB  = 4'hB;
   localparam logic [3:0] OP_AND  = 4'hC;
   localparam logic [3:0] OP_OR   = 4'hD;
   localparam logic [3:0] OP_XOR  = 4'hE;
   localparam logic [3:0] OP_NOP  = 4'hF;

   localparam logic [7:0] SPI_CMD_READ   = 8'h03;
   localparam int         ADDR_BITS      = 16;
   localparam int         SPI_FRAME_BITS = 8 + ADDR_BITS;

   // SCK half-periods while CS_n is low: 32 full SCK cycles
   localparam logic [5:0] SPI_LAST_HALF  = 6'd63;
   localparam logic [5:0] SPI_DATA_HALF  = 6'd48;

   typedef enum logic [1:0] {
      ST_RESET,
      ST_FETCH,
      ST_EXEC_HI,
      ST_EXEC_LO
   } cpu_state_t;

   typedef enum logic [1:0] {
      SPI_IDLE,
      SPI_XFER,
      SPI_DESEL1,
      SPI_DESEL2
   } spi_state_t;

   function automatic logic [SPI_FRAME_BITS-1:0] spi_frame(input logic [7:0] addr);
      return {SPI_CMD_READ, {(ADDR_BITS-8){1'b0}}, addr};
   endfunction

endpackage

// File: rtl/spi_read_master.sv
// Mode-0 SPI single-byte READ master, SCK = clk/2; start to done is 66 clk (64 with CS_n low, done in 2nd deselect clk).
// No backpressure: i_start is only honoured while idle, o_done is a one-clk pulse with o_data stable until next start.
module spi_read_master
   import spi_cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_start,
   input  logic [7:0] i_addr,
   input  logic       i_miso,
   output logic       o_cs_n,
   output logic       o_sck,
   output logic       o_mosi,
   output logic [7:0] o_data,
   output logic       o_done
);

   logic [SPI_FRAME_BITS-1:0] w_frame;
   logic [SPI_FRAME_BITS-1:0] r_tx;
   logic [7:0]                r_rx;
   logic [5:0]                r_cnt;
   logic                      r_cs_n;
   logic                      r_sck;
   logic                      r_mosi;
   logic                      r_done;
   spi_state_t                r_state;

   assign w_frame = spi_frame(i_addr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= SPI_IDLE;
         r_tx    <= '0;
         r_rx    <= '0;
         r_cnt   <= '0;
         r_cs_n  <= 1'b1;
         r_sck   <= 1'b0;
         r_mosi  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            SPI_IDLE: begin
               if (i_start) begin
                  r_state <= SPI_XFER;
                  r_cs_n  <= 1'b0;
                  r_sck   <= 1'b0;
                  r_mosi  <= w_frame[SPI_FRAME_BITS-1];
                  r_tx    <= {w_frame[SPI_FRAME_BITS-2:0], 1'b0};
                  r_cnt   <= '0;
               end
            end
            SPI_XFER: begin
               r_sck <= ~r_sck;
               r_cnt <= r_cnt + 6'd1;
               // Rising SCK samples MISO in the data phase; falling SCK presents the next MOSI bit
               if (!r_sck) begin
                  if (r_cnt >= SPI_DATA_HALF) begin
                     r_rx <= {r_rx[6:0], i_miso};
                  end
               end else begin
                  r_mosi <= r_tx[SPI_FRAME_BITS-1];
                  r_tx   <= {r_tx[SPI_FRAME_BITS-2:0], 1'b0};
               end
               if (r_cnt == SPI_LAST_HALF) begin
                  r_state <= SPI_DESEL1;
                  r_cs_n  <= 1'b1;
                  r_mosi  <= 1'b0;
               end
            end
            SPI_DESEL1: begin
               r_state <= SPI_DESEL2;
               r_done  <= 1'b1;
            end
            SPI_DESEL2: begin
               r_state <= SPI_IDLE;
            end
            default: begin
               r_state <= SPI_IDLE;
            end
         endcase
      end
   end

   assign o_cs_n = r_cs_n;
   assign o_sck  = r_sck;
   assign o_mosi = r_mosi;
   assign o_data = r_rx;
   assign o_done = r_done;

endmodule

// File: rtl/spi_cpu_top.sv
// Accumulator CPU running straight from SPI RAM: one program byte (two nibble ops) per 68 clk; valid lags LDO by one clk.
// No backpressure: outputs are strobed, never held. SPI_CPU_LOGIC_OPS_EN enables AND/OR/XOR on opcodes C/D/E.
module spi_cpu_top
   import spi_cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [7:0] r_a;
   logic [7:0] r_b;
   logic [7:0] r_s;
   logic [7:0] r_out;
   logic [7:0] r_pc;
   logic [7:0] r_ir;
   logic [7:0] r_spi_addr;
   logic       r_valid;
   logic       r_skip;
   logic       r_start;
   cpu_state_t r_state;

   logic [3:0] w_op;
   logic       w_cs_n;
   logic       w_sck;
   logic       w_mosi;
   logic [7:0] w_data;
   logic       w_done;
   logic       w_unused;

   assign w_unused = &{1'b0, ena, uio_in[7:3], uio_in[1:0]};
   assign w_op     = (r_state == ST_EXEC_HI) ? r_ir[7:4] : r_ir[3:0];

   spi_read_master u_spi (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (r_start),
      .i_addr  (r_spi_addr),
      .i_miso  (uio_in[2]),
      .o_cs_n  (w_cs_n),
      .o_sck   (w_sck),
      .o_mosi  (w_mosi),
      .o_data  (w_data),
      .o_done  (w_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_RESET;
         r_a        <= '0;
         r_b        <= '0;
         r_s        <= '0;
         r_out      <= '0;
         r_pc       <= '0;
         r_ir       <= '0;
         r_spi_addr <= '0;
         r_valid    <= 1'b0;
         r_skip     <= 1'b0;
         r_start    <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            ST_RESET: begin
               r_state    <= ST_FETCH;
               r_start    <= 1'b1;
               r_spi_addr <= r_pc;
            end
            ST_FETCH: begin
               r_start <= 1'b0;
               if (w_done) begin
                  r_ir    <= w_data;
                  r_state <= ST_EXEC_HI;
               end
            end
            ST_EXEC_HI, ST_EXEC_LO: begin
               r_skip <= 1'b0;
               if (!r_skip) begin
                  case (w_op)
                     OP_LDA:  r_a <= {4'h0, ui_in[3:0]};
                     OP_LDB:  r_b <= {4'h0, ui_in[7:4]};
                     OP_LDO: begin
                        r_out   <= r_s;
                        r_valid <= 1'b1;
                     end
                     OP_LDSA: r_s <= r_a;
                     OP_LDSB: r_s <= r_b;
                     OP_LSH:  r_s <= {r_s[6:0], 1'b0};
                     OP_RSH:  r_s <= {1'b0, r_s[7:1]};
                     OP_CLR:  r_s <= '0;
                     OP_SNZA: r_skip <= (r_a != 8'h00);
                     OP_SNZS: r_skip <= (r_s != 8'h00);
                     OP_ADD:  r_s <= r_a + r_b;
                     OP_SUB:  r_s <= r_a - r_b;
`ifdef SPI_CPU_LOGIC_OPS_EN
                     OP_AND:  r_s <= r_a & r_b;
                     OP_OR:   r_s <= r_a | r_b;
                     OP_XOR:  r_s <= r_a ^ r_b;
                     OP_NOP:  ;
`else
                     OP_AND, OP_OR, OP_XOR, OP_NOP: ;
`endif
                  endcase
               end
               // Next fetch is launched during EXEC_LO so CS_n falls on the clk that ends it
               if (r_state == ST_EXEC_HI) begin
                  r_state    <= ST_EXEC_LO;
                  r_start    <= 1'b1;
                  r_spi_addr <= r_pc + 8'd1;
               end else begin
                  r_state <= ST_FETCH;
                  r_pc    <= r_pc + 8'd1;
               end
            end
            default: begin
               r_state <= ST_RESET;
            end
         endcase
      end
   end

   assign uo_out  = {r_valid, r_out[6:0]};
   assign uio_out = {r_out[7], 3'b000, w_sck, 1'b0, w_mosi, w_cs_n};
   assign uio_oe  = 8'b1000_1011;

endmodule

// File: tb/tb_spi_cpu_top.sv
// Bench for spi_cpu_top: SPI RAM model behind the pins, expected OUT values queued per program and popped on valid.
// SPI headers and per-transaction SCK/CS_n shape are checked by a pin monitor.
module tb_spi_cpu_top;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;
   logic       miso = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]  mem [256];
   logic [7:0]  q_out [$];
   logic [23:0] q_hdr [$];
   logic [7:0]  exp_b;
   logic [23:0] exp_h;
   logic [7:0]  cur_byte;

   int          sp_rises = 0;
   int          sp_low = 0;
   logic [23:0] sp_hdr = '0;

   wire cs_n = uio_out[0];
   wire mosi = uio_out[1];
   wire sck  = uio_out[3];

   assign uio_in = {5'b00000, miso, 2'b00};

   always #5 clk = ~clk;

   spi_cpu_top dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // SPI RAM model: captures the 24-bit header, returns mem[addr] MSB first on falling SCK
   always @(negedge cs_n) begin
      sp_rises = 0;
      sp_low   = 0;
      sp_hdr   = '0;
   end

   always @(posedge sck) begin
      if (!cs_n) begin
         if (sp_rises < 24) sp_hdr = {sp_hdr[22:0], mosi};
         sp_rises++;
         if (sp_rises == 24 && rst_n && q_hdr.size() != 0) begin
            exp_h = q_hdr.pop_front();
            check("spi_hdr", sp_hdr, exp_h);
         end
      end
   end

   always @(negedge sck) begin
      if (!cs_n && sp_rises >= 24 && sp_rises < 32) begin
         cur_byte = mem[sp_hdr[7:0]];
         miso = cur_byte[31 - sp_rises];
      end
   end

   always @(negedge clk) begin
      if (rst_n && !cs_n) sp_low++;
   end

   always @(posedge cs_n) begin
      if (rst_n) begin
         check("sck_rises", sp_rises, 32);
         check("cs_low_clks", sp_low, 64);
      end
   end

   always @(negedge clk) begin
      if (rst_n && uo_out[7]) begin
         if (q_out.size() != 0) begin
            exp_b = q_out.pop_front();
            check("out", {uio_out[7], uo_out[6:0]}, exp_b);
         end else begin
            check("extra_valid", uo_out[7], 1'b0);
         end
      end
   end

   task automatic load_prog(input logic [31:0] prog);
      for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
      for (int i = 0; i < 4; i++) mem[i] = prog[31-8*i -: 8];
   endtask

   task automatic push_exp(input int n, input logic [31:0] outs);
      q_out.delete();
      q_hdr.delete();
      for (int i = 0; i < n; i++) q_out.push_back(outs[31-8*i -: 8]);
      q_hdr.push_back(24'h030000);
      q_hdr.push_back(24'h030001);
   endtask

   task automatic release_and_run(input string name);
      int k;
      @(negedge clk);
      rst_n = 1'b1;
      for (k = 1; k <= 3; k++) begin
         @(posedge clk);
         #1;
         if (!cs_n) break;
      end
      check({name, "_cs_fall_1to2"}, (k >= 1 && k <= 2), 1'b1);
      for (int c = 0; c < 400 && q_out.size() != 0; c++) @(negedge clk);
      check({name, "_outs_left"}, q_out.size(), 0);
      repeat (70) @(negedge clk);
      check({name, "_hdrs_left"}, q_hdr.size(), 0);
   endtask

   task automatic run_scn(input string name, input logic [7:0] ui, input logic [31:0] prog,
                          input int n, input logic [31:0] outs);
      @(negedge clk);
      #2 rst_n = 1'b0;
      ui_in = ui;
      load_prog(prog);
      push_exp(n, outs);
      repeat (2) @(negedge clk);
      check({name, "_rst_uo"}, uo_out, 8'h00);
      check({name, "_rst_uio"}, uio_out, 8'h01);
      check({name, "_oe"}, uio_oe, 8'h8B);
      release_and_run(name);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      run_scn("add",      8'h35, 32'h10A23242, 3, 32'h08050300);
      // Reset in the middle of a fetch: CS_n must rise at once and state must be cleared
      begin
         int c;
         for (c = 0; c < 100 && cs_n; c++) @(negedge clk);
         check("mid_cs_seen", cs_n, 1'b0);
         repeat (20) @(negedge clk);
         load_prog(32'h2F3242FF);
         #2 rst_n = 1'b0;
         push_exp(3, 32'h00000000);
         #1;
         check("mid_rst_cs_n", cs_n, 1'b1);
         check("mid_rst_uo", uo_out, 8'h00);
         check("mid_rst_uio", uio_out, 8'h01);
         repeat (2) @(negedge clk);
         release_and_run("mid_rst");
      end
      run_scn("sub",      8'h35, 32'h10B2FFFF, 1, 32'h02000000);
      run_scn("sub_wrap", 8'h53, 32'h10B2FFFF, 1, 32'hFE000000);
      run_scn("shift",    8'h35, 32'h10352F62, 2, 32'h0A050000);
      run_scn("lsh_drop", 8'h0F, 32'h03555552, 1, 32'hE0000000);
      run_scn("rsh_log",  8'h0F, 32'h03555562, 1, 32'h78000000);
      run_scn("snza_skp", 8'h05, 32'h0832FFFF, 1, 32'h00000000);
      run_scn("snza_run", 8'h00, 32'h0832FFFF, 1, 32'h00000000);
      run_scn("skip_x",   8'h05, 32'h030872FF, 1, 32'h05000000);
      run_scn("snzs_in",  8'h05, 32'h03972FFF, 1, 32'h05000000);
      run_scn("clr",      8'h05, 32'h0372FFFF, 1, 32'h00000000);
      run_scn("ldo_b2b",  8'h05, 32'h0322FFFF, 2, 32'h05050000);
`ifdef SPI_CPU_LOGIC_OPS_EN
      run_scn("and_xor",  8'h35, 32'h10A2C2E2, 3, 32'h08010600);
      run_scn("or",       8'h35, 32'h10D2FFFF, 1, 32'h07000000);
`else
      run_scn("and_xor",  8'h35, 32'h10A2C2E2, 3, 32'h08080800);
      run_scn("or",       8'h35, 32'h10D2FFFF, 1, 32'h00000000);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      logic done_flag;
      done_flag = 1'b0;
      #2_000_000;
      check("watchdog_done", done_flag, 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
